// File: rtl/sap_pkg.sv
// Shared constants for the SAP CPU control path: opcodes, T-states and control-word bit slots.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    // Control word bit indices; every bit is active high inside the sequencer.
    localparam int unsigned CW_CE = 0;
    localparam int unsigned CW_J  = 1;
    localparam int unsigned CW_CO = 2;
    localparam int unsigned CW_MI = 3;
    localparam int unsigned CW_RI = 4;
    localparam int unsigned CW_RO = 5;
    localparam int unsigned CW_II = 6;
    localparam int unsigned CW_IO = 7;
    localparam int unsigned CW_AI = 8;
    localparam int unsigned CW_AO = 9;
    localparam int unsigned CW_EO = 10;
    localparam int unsigned CW_SU = 11;
    localparam int unsigned CW_BI = 12;
    localparam int unsigned CW_OI = 13;
    localparam int unsigned CW_FI = 14;
    localparam int unsigned CW_W  = 15;

    // NOP and the unassigned opcodes 0x9-0xD end after fetch.
    function automatic logic has_execute(input logic [3:0] op);
        return !((op == OP_NOP) || ((op >= 4'h9) && (op <= 4'hD)));
    endfunction

endpackage

// File: rtl/step_counter.sv
// T-state counter with synchronous clear, advance enable and early wrap to T0.
module step_counter #(
    parameter int unsigned STEP_W = 3
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              advance,
    input  logic              wrap_to_zero,
    output logic [STEP_W-1:0] count
);

    logic [STEP_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            count_q <= '0;
        end else if (advance) begin
            count_q <= wrap_to_zero ? '0 : count_q + STEP_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcoded SAP control unit: walks fetch/execute T-states and drives every datapath control line.
module control_sequencer
    import sap_pkg::*;
#(
    parameter int unsigned STEP_W   = 3,
    parameter int unsigned OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                clear_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                carry_flag,
    input  logic                zero_flag,
    output logic                pc_enable,
    output logic                pc_jump_n,
    output logic                pc_bus_enable_n,
    output logic                mar_load_n,
    output logic                ram_write,
    output logic                ram_out_n,
    output logic                ir_load_n,
    output logic                ir_out_n,
    output logic                a_load_n,
    output logic                a_out_n,
    output logic                alu_out_n,
    output logic                alu_sub,
    output logic                b_load_n,
    output logic                out_load_n,
    output logic                flags_load_n,
    output logic                halted,
    output logic [STEP_W-1:0]   step
);

    logic            halted_q;
    logic            run;
    logic            last_step;
    logic            hlt_step;
    logic [CW_W-1:0] cw;
    logic [CW_W-1:0] cw_act;
    logic [3:0]      op;
    logic [2:0]      st;

    assign op  = 4'(opcode);
    assign st  = 3'(step);
    assign run = clear_n && !halted_q;

    step_counter #(
        .STEP_W (STEP_W)
    ) u_step_counter (
        .clk          (clk),
        .clear        (!clear_n),
        .advance      (!halted_q),
        .wrap_to_zero (last_step),
        .count        (step)
    );

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            halted_q <= 1'b0;
        end else if (run && hlt_step) begin
            halted_q <= 1'b1;
        end
    end

    always_comb begin
        cw        = '0;
        last_step = 1'b0;
        hlt_step  = 1'b0;
        if (st == T0) begin
            cw[CW_CO] = 1'b1;
            cw[CW_MI] = 1'b1;
        end else if (st == T1) begin
            cw[CW_RO] = 1'b1;
            cw[CW_II] = 1'b1;
            cw[CW_CE] = 1'b1;
            last_step = !has_execute(op);
        end else begin
            case ({op, st})
                {OP_LDA, T2}, {OP_ADD, T2}, {OP_SUB, T2}, {OP_STA, T2}: begin
                    cw[CW_IO] = 1'b1;
                    cw[CW_MI] = 1'b1;
                end
                {OP_LDA, T3}: begin
                    cw[CW_RO] = 1'b1;
                    cw[CW_AI] = 1'b1;
                    last_step = 1'b1;
                end
                {OP_ADD, T3}, {OP_SUB, T3}: begin
                    cw[CW_RO] = 1'b1;
                    cw[CW_BI] = 1'b1;
                end
                {OP_ADD, T4}, {OP_SUB, T4}: begin
                    cw[CW_EO] = 1'b1;
                    cw[CW_AI] = 1'b1;
                    cw[CW_FI] = 1'b1;
                    cw[CW_SU] = (op == OP_SUB);
                    last_step = 1'b1;
                end
                {OP_STA, T3}: begin
                    cw[CW_AO] = 1'b1;
                    cw[CW_RI] = 1'b1;
                    last_step = 1'b1;
                end
                {OP_LDI, T2}: begin
                    cw[CW_IO] = 1'b1;
                    cw[CW_AI] = 1'b1;
                    last_step = 1'b1;
                end
                {OP_JMP, T2}, {OP_JC, T2}, {OP_JZ, T2}: begin
                    // Conditional jumps still spend T2 even when the branch is not taken.
                    if ((op == OP_JMP) || ((op == OP_JC) && carry_flag)
                            || ((op == OP_JZ) && zero_flag)) begin
                        cw[CW_IO] = 1'b1;
                        cw[CW_J]  = 1'b1;
                    end
                    last_step = 1'b1;
                end
                {OP_OUT, T2}: begin
                    cw[CW_AO] = 1'b1;
                    cw[CW_OI] = 1'b1;
                    last_step = 1'b1;
                end
                {OP_HLT, T2}: begin
                    hlt_step  = 1'b1;
                    last_step = 1'b1;
                end
                default: begin
                    // Unused {opcode, step} pairs fall back to a fresh fetch.
                    last_step = 1'b1;
                end
            endcase
        end
    end

    assign cw_act = run ? cw : '0;

    assign pc_enable       =  cw_act[CW_CE];
    assign pc_jump_n       = ~cw_act[CW_J];
    assign pc_bus_enable_n = ~cw_act[CW_CO];
    assign mar_load_n      = ~cw_act[CW_MI];
    assign ram_write       =  cw_act[CW_RI];
    assign ram_out_n       = ~cw_act[CW_RO];
    assign ir_load_n       = ~cw_act[CW_II];
    assign ir_out_n        = ~cw_act[CW_IO];
    assign a_load_n        = ~cw_act[CW_AI];
    assign a_out_n         = ~cw_act[CW_AO];
    assign alu_out_n       = ~cw_act[CW_EO];
    assign alu_sub         =  cw_act[CW_SU];
    assign b_load_n        = ~cw_act[CW_BI];
    assign out_load_n      = ~cw_act[CW_OI];
    assign flags_load_n    = ~cw_act[CW_FI];
    assign halted          = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clear_n;
    logic [3:0] opcode;
    logic       carry_flag;
    logic       zero_flag;
    logic       pc_enable, pc_jump_n, pc_bus_enable_n, mar_load_n, ram_write, ram_out_n;
    logic       ir_load_n, ir_out_n, a_load_n, a_out_n, alu_out_n, alu_sub, b_load_n;
    logic       out_load_n, flags_load_n, halted;
    logic [2:0] step;

    int n_cmp = 0;
    int n_err = 0;

    // Output bundle, MSB first: CE J CO MI RI RO II IO AI AO EO SU BI OI FI.
    logic [14:0] ctl;
    localparam logic [14:0] INACT = 15'b0111_0111_1110_111;
    localparam logic [14:0] M_CE = 15'h4000, M_J  = 15'h2000, M_CO = 15'h1000;
    localparam logic [14:0] M_MI = 15'h0800, M_RI = 15'h0400, M_RO = 15'h0200;
    localparam logic [14:0] M_II = 15'h0100, M_IO = 15'h0080, M_AI = 15'h0040;
    localparam logic [14:0] M_AO = 15'h0020, M_EO = 15'h0010, M_SU = 15'h0008;
    localparam logic [14:0] M_BI = 15'h0004, M_OI = 15'h0002, M_FI = 15'h0001;
    localparam logic [14:0] F0 = M_CO | M_MI;
    localparam logic [14:0] F1 = M_RO | M_II | M_CE;

    typedef logic [14:0] seq_t [5];

    assign ctl = {pc_enable, pc_jump_n, pc_bus_enable_n, mar_load_n, ram_write, ram_out_n,
                  ir_load_n, ir_out_n, a_load_n, a_out_n, alu_out_n, alu_sub, b_load_n,
                  out_load_n, flags_load_n};

    control_sequencer #(
        .STEP_W   (3),
        .OPCODE_W (4)
    ) dut (
        .clk             (clk),
        .clear_n         (clear_n),
        .opcode          (opcode),
        .carry_flag      (carry_flag),
        .zero_flag       (zero_flag),
        .pc_enable       (pc_enable),
        .pc_jump_n       (pc_jump_n),
        .pc_bus_enable_n (pc_bus_enable_n),
        .mar_load_n      (mar_load_n),
        .ram_write       (ram_write),
        .ram_out_n       (ram_out_n),
        .ir_load_n       (ir_load_n),
        .ir_out_n        (ir_out_n),
        .a_load_n        (a_load_n),
        .a_out_n         (a_out_n),
        .alu_out_n       (alu_out_n),
        .alu_sub         (alu_sub),
        .b_load_n        (b_load_n),
        .out_load_n      (out_load_n),
        .flags_load_n    (flags_load_n),
        .halted          (halted),
        .step            (step)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Walks one instruction from T0, checking step and control lines in each T-state.
    task automatic run_seq(input string tag, input logic [3:0] op, input logic c,
                           input logic z, input int n, input seq_t m);
        opcode     = op;
        carry_flag = c;
        zero_flag  = z;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check($sformatf("%s_step%0d", tag, i), 32'(step), 32'(i));
            check($sformatf("%s_ctl%0d", tag, i), 32'(ctl), 32'(INACT ^ m[i]));
            @(posedge clk);
            #1;
        end
        check($sformatf("%s_wrap", tag), 32'(step), 32'd0);
    endtask

    int cyc_tab [16] = '{2, 4, 5, 5, 4, 3, 3, 3, 3, 2, 2, 2, 2, 2, 3, 3};

    initial begin
        clear_n    = 1'b0;
        opcode     = 4'h0;
        carry_flag = 1'b0;
        zero_flag  = 1'b0;

        // Reset
        next_cycle();
        check("rst_ctl", 32'(ctl), 32'(INACT));
        next_cycle();
        clear_n = 1'b1;
        #1;
        check("rst_step", 32'(step), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_t0", 32'(ctl), 32'(INACT ^ F0));

        run_seq("add", 4'h2, 1'b0, 1'b0, 5, '{F0, F1, M_IO | M_MI, M_RO | M_BI,
                                                M_EO | M_AI | M_FI});
        run_seq("sub", 4'h3, 1'b1, 1'b1, 5, '{F0, F1, M_IO | M_MI, M_RO | M_BI,
                                                M_EO | M_AI | M_FI | M_SU});
        run_seq("lda", 4'h1, 1'b0, 1'b0, 4, '{F0, F1, M_IO | M_MI, M_RO | M_AI, 15'h0});
        run_seq("jc1", 4'h7, 1'b1, 1'b0, 3, '{F0, F1, M_IO | M_J, 15'h0, 15'h0});
        run_seq("jc0", 4'h7, 1'b0, 1'b1, 3, '{F0, F1, 15'h0, 15'h0, 15'h0});
        run_seq("jz1", 4'h8, 1'b0, 1'b1, 3, '{F0, F1, M_IO | M_J, 15'h0, 15'h0});
        run_seq("ldi", 4'h5, 1'b0, 1'b0, 3, '{F0, F1, M_IO | M_AI, 15'h0, 15'h0});
        run_seq("out", 4'hE, 1'b0, 1'b0, 3, '{F0, F1, M_AO | M_OI, 15'h0, 15'h0});
        run_seq("nop", 4'hB, 1'b0, 1'b0, 2, '{F0, F1, 15'h0, 15'h0, 15'h0});

        // STA abandoned by a reset during T3
        opcode = 4'h4;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
        end
        check("sta_t3_step", 32'(step), 32'd3);
        check("sta_t3_ctl", 32'(ctl), 32'(INACT ^ (M_AO | M_RI)));
        clear_n = 1'b0;
        #1;
        check("sta_rst_ram_write", 32'(ram_write), 32'd0);
        check("sta_rst_ctl", 32'(ctl), 32'(INACT));
        next_cycle();
        check("sta_rst_step", 32'(step), 32'd0);
        clear_n = 1'b1;
        #1;
        check("sta_resume", 32'(ctl), 32'(INACT ^ F0));

        // HLT then hold, then clear
        run_seq("hlt", 4'hF, 1'b0, 1'b0, 3, '{F0, F1, 15'h0, 15'h0, 15'h0});
        check("hlt_halted", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            check("hlt_hold_step", 32'(step), 32'd0);
            check("hlt_hold_ctl", 32'(ctl), 32'(INACT));
        end
        clear_n = 1'b0;
        next_cycle();
        clear_n = 1'b1;
        #1;
        check("hlt_clr_halted", 32'(halted), 32'd0);
        check("hlt_clr_step", 32'(step), 32'd0);
        check("hlt_clr_ctl", 32'(ctl), 32'(INACT ^ F0));

        // Opcode sweep: cycle counts and bus-driver exclusivity
        carry_flag = 1'b1;
        zero_flag  = 1'b1;
        for (int op = 0; op < 16; op++) begin
            int cnt;
            int drivers;
            opcode = 4'(op);
            cnt = 0;
            for (int k = 0; k < 8; k++) begin
                #1;
                drivers = int'(!pc_bus_enable_n) + int'(!ram_out_n) + int'(!ir_out_n)
                        + int'(!a_out_n) + int'(!alu_out_n);
                check($sformatf("bus_op%0h", op), 32'(drivers > 1), 32'd0);
                check($sformatf("cejmp_op%0h", op), 32'(pc_enable && !pc_jump_n), 32'd0);
                cnt++;
                next_cycle();
                if (step == 3'd0) break;
            end
            check($sformatf("cycles_op%0h", op), 32'(cnt), 32'(cyc_tab[op]));
        end
        check("sweep_halted", 32'(halted), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
